// File: rtl/ccff_stream_loader.sv
// Streams WORD_W-bit bitstream words, MSB first, into a serial configuration
// chain of CHAIN_LEN bits. Words that arrive late just insert FETCH bubbles;
// the chain only shifts while the loader is in SHIFT.
module ccff_stream_loader #(
    parameter int CHAIN_LEN = 36,
    parameter int WORD_W    = 8
) (
    input  logic              prog_clk,
    input  logic              pReset,
    input  logic              start,
    input  logic              abort,
    input  logic [WORD_W-1:0] din,
    input  logic              din_valid,
    output logic              din_ready,
    output logic              ccff_head,
    output logic              config_enable,
    output logic              busy,
    output logic              done,
    output logic              aborted,
    output logic [15:0]       bit_count
);

    localparam int IDX_W = $clog2(WORD_W);

    typedef enum logic [1:0] {IDLE, FETCH, SHIFT, FINISH} state_t;

    state_t            state, state_nxt;
    logic [WORD_W-1:0] sreg;
    logic [IDX_W-1:0]  idx;
    logic              aborted_q;
    logic              last_bit;
    logic              word_end;

    // Bit about to be shifted is the last of the load / of the current word.
    assign last_bit = (bit_count == 16'(CHAIN_LEN - 1));
    assign word_end = (idx == IDX_W'(WORD_W - 1));
    assign aborted  = aborted_q;

    // State register.
    always_ff @(posedge prog_clk) begin
        if (pReset) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state and Moore/Mealy outputs; abort gates the handshake and done
    // so a cancelled load never takes a word or reports completion.
    always_comb begin
        state_nxt     = state;
        din_ready     = 1'b0;
        config_enable = 1'b0;
        ccff_head     = 1'b0;
        done          = 1'b0;
        busy          = (state != IDLE);
        case (state)
            IDLE: begin
                if (start && !abort) state_nxt = FETCH;
            end
            FETCH: begin
                din_ready = !abort;
                if (abort)          state_nxt = IDLE;
                else if (din_valid) state_nxt = SHIFT;
            end
            SHIFT: begin
                config_enable = 1'b1;
                ccff_head     = sreg[WORD_W-1];
                if (abort)         state_nxt = IDLE;
                else if (last_bit) state_nxt = FINISH;
                else if (word_end) state_nxt = FETCH;
            end
            FINISH: begin
                done      = !abort;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: word capture, shift register, in-word index, bit counter and
    // the registered abort pulse. The shift in an abort cycle still happens
    // (config_enable is already high), so bit_count counts it.
    always_ff @(posedge prog_clk) begin
        if (pReset) begin
            sreg      <= '0;
            idx       <= '0;
            bit_count <= '0;
            aborted_q <= 1'b0;
        end else begin
            aborted_q <= abort && (state != IDLE);
            if (state == IDLE && start && !abort) bit_count <= '0;
            if (din_ready && din_valid) begin
                sreg <= din;
                idx  <= '0;
            end
            if (config_enable) begin
                sreg      <= sreg << 1;
                idx       <= idx + 1'b1;
                bit_count <= bit_count + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_ccff_stream_loader.sv
// Directed bench for ccff_stream_loader (CHAIN_LEN=36, WORD_W=8).
module tb_ccff_stream_loader;

    logic        prog_clk = 1'b0;
    logic        pReset, start, abort, din_valid;
    logic [7:0]  din;
    logic        din_ready, ccff_head, config_enable, busy, done, aborted;
    logic [15:0] bit_count;

    ccff_stream_loader #(.CHAIN_LEN(36), .WORD_W(8)) dut (
        .prog_clk(prog_clk), .pReset(pReset), .start(start), .abort(abort),
        .din(din), .din_valid(din_valid), .din_ready(din_ready),
        .ccff_head(ccff_head), .config_enable(config_enable), .busy(busy),
        .done(done), .aborted(aborted), .bit_count(bit_count)
    );

    always #5 prog_clk = ~prog_clk;

    int n_asrt = 0;
    int n_fail = 0;

    logic [7:0]  words [5] = '{8'hA5, 8'h3C, 8'hFF, 8'h00, 8'h90};
    logic [35:0] ser;
    int          nsh, ndone, nab, done_cyc, ab_cyc;
    logic [21:0] rst_outs;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_asrt++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drives one load for ncyc cycles; cycle 0 carries start. Optional
    // abort / extra start / reset at given cycle numbers (0 = unused).
    // gap = FETCH cycles with din_valid low before each word is offered.
    task automatic run_load(input int gap, input int abort_cyc, input int start_cyc,
                            input int rst_cyc, input int ncyc);
        int   widx = 0;
        int   gcnt = 0;
        logic acc  = 1'b0;
        logic rdy  = 1'b0;
        ser = '0; nsh = 0; ndone = 0; nab = 0; done_cyc = -1; ab_cyc = -1;
        rst_outs = '1;
        for (int c = 0; c < ncyc; c++) begin
            @(posedge prog_clk); #1;
            if (acc) begin widx++; gcnt = 0; end
            else if (rdy) gcnt++;
            start     = (c == 0) || (start_cyc > 0 && c == start_cyc);
            abort     = (abort_cyc > 0 && c == abort_cyc);
            pReset    = (rst_cyc > 0 && c == rst_cyc);
            din_valid = (gcnt >= gap);
            din       = (widx < 5) ? words[widx] : 8'h00;
            @(negedge prog_clk);
            acc = din_ready && din_valid;
            rdy = din_ready;
            if (config_enable) begin ser = {ser[34:0], ccff_head}; nsh++; end
            if (done)    begin ndone++; done_cyc = c; end
            if (aborted) begin nab++;   ab_cyc = c;   end
            if (rst_cyc > 0 && c == rst_cyc + 1)
                rst_outs = {din_ready, ccff_head, config_enable, busy, done, aborted, bit_count};
        end
        start = 1'b0; abort = 1'b0; pReset = 1'b0; din_valid = 1'b0;
    endtask

    initial begin
        pReset = 1'b1; start = 1'b0; abort = 1'b0; din_valid = 1'b0; din = 8'h00;
        repeat (2) @(posedge prog_clk);
        @(negedge prog_clk);
        chk("rst_din_ready", din_ready, 0);
        chk("rst_ccff_head", ccff_head, 0);
        chk("rst_config_enable", config_enable, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_aborted", aborted, 0);
        chk("rst_bit_count", bit_count, 0);
        @(posedge prog_clk); #1;
        pReset = 1'b0;

        // Full load, din_valid always high: done at 1 + 36 + 5 = 42.
        run_load(0, 0, 0, 0, 60);
        chk("full_serial", ser, 36'hA53CFF009);
        chk("full_shifts", nsh, 36);
        chk("full_done_count", ndone, 1);
        chk("full_done_cycle", done_cyc, 42);
        chk("full_aborted", nab, 0);
        chk("full_bit_count", bit_count, 36);
        chk("full_busy_end", busy, 0);

        // Three-cycle valid gaps before every word: 5 x 3 extra cycles.
        run_load(3, 0, 0, 0, 70);
        chk("gap_serial", ser, 36'hA53CFF009);
        chk("gap_shifts", nsh, 36);
        chk("gap_done_count", ndone, 1);
        chk("gap_done_cycle", done_cyc, 57);
        chk("gap_bit_count", bit_count, 36);

        // Abort in cycle 12 = 10th shift (FETCH, 8 shifts, FETCH, shift 9, shift 10).
        run_load(0, 12, 0, 0, 60);
        chk("abort_pulses", nab, 1);
        chk("abort_pulse_cycle", ab_cyc, 13);
        chk("abort_done_count", ndone, 0);
        chk("abort_shifts", nsh, 10);
        chk("abort_bit_count", bit_count, 10);
        chk("abort_busy_end", busy, 0);

        // Second start during SHIFT is ignored.
        run_load(0, 0, 5, 0, 60);
        chk("busy_start_done_count", ndone, 1);
        chk("busy_start_done_cycle", done_cyc, 42);
        chk("busy_start_serial", ser, 36'hA53CFF009);
        chk("busy_start_bit_count", bit_count, 36);

        // Reset during SHIFT: everything low next cycle, no pulses.
        run_load(0, 0, 0, 6, 30);
        chk("midrst_outputs", rst_outs, 22'h0);
        chk("midrst_done_count", ndone, 0);
        chk("midrst_aborted", nab, 0);
        chk("midrst_busy_end", busy, 0);

        // Fresh load after the mid-load reset.
        run_load(0, 0, 0, 0, 60);
        chk("reload_serial", ser, 36'hA53CFF009);
        chk("reload_done_count", ndone, 1);
        chk("reload_bit_count", bit_count, 36);

        // start and abort together in IDLE: ignored, bit_count kept.
        @(posedge prog_clk); #1;
        start = 1'b1; abort = 1'b1;
        @(posedge prog_clk); #1;
        start = 1'b0; abort = 1'b0;
        @(negedge prog_clk);
        chk("sa_busy", busy, 0);
        chk("sa_din_ready", din_ready, 0);
        chk("sa_aborted", aborted, 0);
        chk("sa_done", done, 0);
        chk("sa_bit_count", bit_count, 36);
        @(posedge prog_clk);
        @(negedge prog_clk);
        chk("sa_busy_later", busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end

endmodule
